fifo_write_ctrl: RTL

//  Write-side pointer and flag controller of the dual-clock CDC FIFO; it is the producer end of the

---
 rtl/fifo_write_ctrl_pkg.sv | 9 +
 rtl/cdc_sync_2ff.sv | 27 ++
 rtl/fifo_write_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/fifo_write_ctrl_pkg.sv
// Shared sizing defaults for the CDC FIFO write/read controllers.
// Pointers carry one extra wrap bit above the address bits.
package fifo_write_ctrl_pkg;

  localparam int ADDR_W_DFLT  = 4;
  localparam int WRAP_BITS    = 1;
  localparam int AFULL_MARGIN = 2;

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing clock domains.
// Shared by the write side (read pointer) and the read side (write pointer).
module cdc_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/flag controller of the dual-clock FIFO.
// Optional almost-full output: define FIFO_WR_ALMOST_FULL_EN.
module fifo_write_ctrl
  import fifo_write_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DFLT,
`ifdef FIFO_WR_ALMOST_FULL_EN
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - AFULL_MARGIN,
`endif
  parameter int PTR_WIDTH   = ADDR_WIDTH + WRAP_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [PTR_WIDTH-1:0]  w_rptr_gray,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0]  wptr,
  output logic [PTR_WIDTH-1:0]  wptr_gray,
  output logic                  wfull,
  output logic [PTR_WIDTH-1:0]  wlevel,
`ifdef FIFO_WR_ALMOST_FULL_EN
  output logic                  walmost_full,
`endif
  output logic                  wovf
);

  localparam int MSB = PTR_WIDTH - 1;

  logic [PTR_WIDTH-1:0] rq2;
  logic [PTR_WIDTH-1:0] rq_bin;
  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] wgray_q, wgray_d;
  logic                 wovf_q, wovf_d;

  cdc_sync_2ff #(
    .WIDTH (PTR_WIDTH)
  ) u_rsync (
    .clk (clk),
    .rst (rst),
    .d   (w_rptr_gray),
    .q   (rq2)
  );

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      rq_bin[i] = ^(rq2 >> i);
    end
  end

  // Full when pointers differ only in the wrap bit.
  assign wfull = (wptr_q[MSB] != rq_bin[MSB]) &&
                 (wptr_q[MSB-1:0] == rq_bin[MSB-1:0]);

  // Held reset blocks the strobe even with winc high.
  assign wen = winc & ~wfull & rst;

  always_comb begin
    wptr_d  = wptr_q;
    wovf_d  = wovf_q;
    if (wen) begin
      wptr_d = wptr_q + PTR_WIDTH'(1);
    end
    if (winc && wfull) begin
      wovf_d = 1'b1;
    end
    wgray_d = wptr_d ^ (wptr_d >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      wgray_q <= '0;
      wovf_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      wgray_q <= wgray_d;
      wovf_q  <= wovf_d;
    end
  end

  assign wptr      = wptr_q;
  assign wptr_gray = wgray_q;
  assign waddr     = wptr_q[ADDR_WIDTH-1:0];
  assign wlevel    = wptr_q - rq_bin;
  assign wovf      = wovf_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
  assign walmost_full = (wlevel >= PTR_WIDTH'(AFULL_LEVEL));
`endif

endmodule
